uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles in ISSUE waiting for i_tx_ready to drop.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port i_req_valid, input, NUM_REQ bits: per-requester byte-valid.
REQ-006 The block SHALL have port i_req_data, input, NUM_REQ*8 bits: requester r byte at bits [8r+7:8r].
REQ-007 The block SHALL have port o_req_ready, output, NUM_REQ bits: per-requester accept; at most one bit set.
REQ-008 The block SHALL have port o_tx_valid, output, 1 bit: to uart_tx i_valid.
REQ-009 The block SHALL have port o_tx_data, output, 8 bits: to uart_tx i_data, registered.
REQ-010 The block SHALL have port i_tx_ready, input, 1 bit: from uart_tx o_ready (high only when uart_tx idle).
REQ-011 The block SHALL have port o_grant, output, NUM_REQ bits: one-hot owner of the transmitter, registered.
REQ-012 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a frame start is aborted.

Function
REQ-013 The block SHALL implement FSM states IDLE, ISSUE, SEND.
REQ-014 In IDLE with i_tx_ready=1 and any i_req_valid set, the block SHALL raise o_req_ready combinationally for exactly the round-robin winner; transfer occurs when valid&&ready are both high.
REQ-015 Round-robin search SHALL start at index (last_grant+1) mod NUM_REQ and ascend with wrap; the first set valid bit wins.
REQ-016 On a transfer, the block SHALL at the next edge load o_tx_data with the winner's byte, set o_grant one-hot to the winner, set last_grant, and enter ISSUE.
REQ-017 In IDLE with i_tx_ready=0, o_req_ready SHALL be all zero and no transfer SHALL occur.
REQ-018 o_tx_valid SHALL be 1 exactly when state is ISSUE.
REQ-019 In ISSUE, when i_tx_ready=0 is sampled, the block SHALL enter SEND and clear the ISSUE counter.
REQ-020 In SEND, o_tx_data and o_grant SHALL be held stable, since uart_tx reads i_data bit by bit for the whole frame.
REQ-021 In SEND, when i_tx_ready=1 is sampled, the block SHALL enter IDLE and clear o_grant; a new grant is allowed in that same IDLE cycle.
REQ-022 In ISSUE, the counter SHALL increment each cycle that i_tx_ready=1.
REQ-023 If the counter reaches TIMEOUT_CYCLES-1 with i_tx_ready still 1, the block SHALL pulse o_timeout for one cycle, drop the byte, clear o_grant, and return to IDLE; last_grant keeps its value.
REQ-024 Requester valid changes outside IDLE SHALL be ignored; o_req_ready SHALL be 0 in ISSUE and SEND.
REQ-025 Minimum spacing between consecutive accepts SHALL be one full uart frame plus 2 cycles; there is no internal buffering beyond o_tx_data.

Reset
REQ-026 With reset_n=0 at a rising edge, the block SHALL enter IDLE, clear o_tx_data to 0, o_grant to 0, o_timeout to 0, and the counter to 0, and set last_grant to NUM_REQ-1 (requester 0 has first priority).
REQ-027 During reset, o_req_ready and o_tx_valid SHALL be 0.
REQ-028 Reset asserted mid-ISSUE or mid-SEND SHALL abandon the byte without an o_timeout pulse.

Verification
REQ-029 Single request: requester 2 presents 0xA5 with uart_tx idle -> o_req_ready=4'b0100 for one cycle; o_tx_data=0xA5, o_grant=4'b0100; the serial line carries 0xA5; FSM returns to IDLE.
REQ-030 Fairness: all four valid continuously with bytes 0x10..0x13 -> grant order 0,1,2,3,0; each grant is held until i_tx_ready returns high.
REQ-031 Wrap: after a grant to 3, requesters 1 and 3 valid -> requester 1 wins next.
REQ-032 Timeout: i_tx_ready forced high after an accept -> o_timeout pulses exactly 16 cycles after entering ISSUE; state is IDLE; o_grant=0.
REQ-033 Busy hold-off: i_tx_ready=0 in IDLE while requester 0 is valid -> no o_req_ready until i_tx_ready rises.
REQ-034 Reset mid-SEND: reset_n low for one cycle -> all outputs reach reset values; the next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources.
// Holds the winning byte and grant for the whole frame, and aborts a start that uart_tx never takes.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_timeout
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SEND} state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [CW-1:0] cnt;
    logic [IW-1:0] winner;
    logic          found;
    logic          accept;

    function automatic logic [IW-1:0] rr_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IW-1:0];
    endfunction

    // Search starts just past the previous owner and wraps, so every requester is reached in turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && i_req_valid[rr_idx(int'(last_grant), off)]) begin
                winner = rr_idx(int'(last_grant), off);
                found  = 1'b1;
            end
        end
    end

    assign accept = reset_n && (state == IDLE) && i_tx_ready && found;

    always_comb begin
        o_req_ready = '0;
        if (accept) o_req_ready[winner] = 1'b1;
    end

    assign o_tx_valid = reset_n && (state == ISSUE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            o_tx_data  <= '0;
            o_grant    <= '0;
            o_timeout  <= 1'b0;
            cnt        <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_tx_data  <= i_req_data[8*int'(winner) +: 8];
                        o_grant    <= o_req_ready;
                        last_grant <= winner;
                        cnt        <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // uart_tx drops ready once it has latched the byte and started the frame.
                    if (!i_tx_ready) begin
                        cnt   <= '0;
                        state <= SEND;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (i_tx_ready) begin
                        o_grant <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level round-robin model plus a
// behavioural uart_tx that shifts the byte out of o_tx_data during the frame.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           timeout;

    int n_chk = 0;
    int n_err = 0;
    int m_last;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_grant(grant), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Requester chosen by round robin: first valid one after the previous owner.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // One accepted byte: handshake, ISSUE for iw extra cycles, a frame of `frame` cycles, back to IDLE.
    task automatic do_xfer(input logic [N-1:0] mask, input logic [N*8-1:0] data,
                           input int iw, input int frame, output logic [N-1:0] obs);
        int         e;
        logic [7:0] b;
        logic [7:0] rx;
        logic       bad;
        e = rr_pick(m_last, mask);
        b = data[e*8 +: 8];
        req_valid = mask;
        req_data  = data;
        #1;
        obs = req_ready;
        chk("rr_ready", 32'(req_ready), 32'(1 << e));
        cyc();
        req_valid = '0;
        m_last = e;
        chk("issue_valid", 32'(tx_valid), 32'd1);
        chk("tx_data", 32'(tx_data), 32'(b));
        chk("grant", 32'(grant), 32'(1 << e));
        chk("ready_busy", 32'(req_ready), 32'd0);
        repeat (iw) cyc();
        chk("issue_hold", 32'(tx_valid), 32'd1);
        tx_ready = 1'b0;
        cyc();
        req_valid = N'($urandom);
        #1;
        chk("send_ignore", 32'({req_ready, tx_valid}), 32'd0);
        bad = 1'b0;
        rx  = '0;
        for (int k = 0; k < frame; k++) begin
            if (k < 8) rx[k] = tx_data[k];
            if (grant !== N'(1 << e) || tx_data !== b || tx_valid !== 1'b0) bad = 1'b1;
            cyc();
        end
        chk("serial", 32'(rx), 32'(b));
        chk("send_hold", 32'(bad), 32'd0);
        tx_ready = 1'b1;
        cyc();
        chk("grant_clr", 32'(grant), 32'd0);
        req_valid = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] obs;
        // Reset: outputs quiet even with requests pending and uart idle.
        reset_n   = 1'b0;
        tx_ready  = 1'b1;
        req_valid = '1;
        cyc();
        cyc();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        req_valid = '0;
        reset_n   = 1'b1;
        m_last    = N - 1;
        cyc();

        // Fairness: all valid, order 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            do_xfer(4'b1111, 32'h1312_1110, 1, 10, obs);
            chk("fair_order", 32'(obs), 32'(1 << (i % N)));
        end

        // Wrap: after grant to 3, requesters 1 and 3 -> 1.
        do_xfer(4'b1000, 32'($urandom), 0, 10, obs);
        chk("wrap_pre", 32'(obs), 32'b1000);
        do_xfer(4'b1010, 32'($urandom), 2, 11, obs);
        chk("wrap", 32'(obs), 32'b0010);

        // Single request: requester 2 sends 0xA5.
        do_xfer(4'b0100, 32'h00A5_0000, 0, 12, obs);
        chk("single", 32'(obs), 32'b0100);

        // Busy hold-off: uart busy while requester 0 waits.
        tx_ready  = 1'b0;
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("busy_ready", 32'(req_ready), 32'd0);
        end
        tx_ready = 1'b1;
        #1;
        chk("busy_release", 32'(req_ready), 32'(1 << rr_pick(m_last, 4'b0001)));
        req_valid = '0;
        cyc();

        // Timeout: uart never takes the byte.
        req_valid = 4'b0001;
        req_data  = 32'($urandom);
        #1;
        chk("to_ready", 32'(req_ready), 32'(1 << rr_pick(m_last, 4'b0001)));
        cyc();
        req_valid = '0;
        m_last = 0;
        for (int k = 1; k <= TO; k++) begin
            cyc();
            chk("to_pulse", 32'(timeout), 32'(k == TO));
        end
        chk("to_grant", 32'(grant), 32'd0);
        chk("to_valid", 32'(tx_valid), 32'd0);
        cyc();
        chk("to_once", 32'(timeout), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            do_xfer(N'($urandom_range(1, (1 << N) - 1)), {$urandom}, $urandom_range(0, 3),
                    $urandom_range(10, 14), obs);
        end

        // Reset in the middle of a frame.
        req_valid = 4'b0100;
        req_data  = 32'($urandom);
        #1;
        cyc();
        req_valid = '0;
        tx_ready  = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        #1;
        chk("msend_grant", 32'(grant), 32'd0);
        chk("msend_data", 32'(tx_data), 32'd0);
        chk("msend_valid", 32'(tx_valid), 32'd0);
        chk("msend_timeout", 32'(timeout), 32'd0);
        m_last = N - 1;
        do_xfer(4'b1111, 32'($urandom), 1, 10, obs);
        chk("msend_first", 32'(obs), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
